// File: rtl/ula_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ula_op_sequencer
// Description : Collects {opcode, A, B} byte commands, drives the ULA for the
//               op latency and holds the result behind a valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
module ula_op_sequencer #(
    parameter int N       = 8,
    parameter int LAT_ALU = 1,
    parameter int LAT_MUL = 8
) (
    input  logic           Tclk,
    input  logic           Tclr,
    input  logic [N-1:0]   in_data,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [N-1:0]   ula_A,
    output logic [N-1:0]   ula_B,
    output logic [2:0]     ula_sel,
    output logic           ula_en,
    input  logic [N:0]     ula_S,
    input  logic [2*N-1:0] ula_Smulti,
    output logic [2*N-1:0] res_data,
    output logic [2:0]     res_op,
    output logic           res_valid,
    input  logic           res_ready,
    output logic           err
);

    localparam int LAT_MAX = (LAT_MUL > LAT_ALU) ? LAT_MUL : LAT_ALU;
    localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
    localparam logic [CNT_W-1:0] c_cnt_mul = CNT_W'(LAT_MUL - 1);
    localparam logic [CNT_W-1:0] c_cnt_alu = CNT_W'(LAT_ALU - 1);
    localparam logic [2:0]       c_sel_mul = 3'b111;

    typedef enum logic [2:0] {
        ST_GET_OP = 3'd0,
        ST_GET_A  = 3'd1,
        ST_GET_B  = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     b_q, b_d;
    logic [2:0]       sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*N-1:0]   res_data_q, res_data_d;
    logic [2:0]       res_op_q, res_op_d;
    logic             res_valid_q, res_valid_d;
    logic             err_q, err_d;

    always_ff @(posedge Tclk) begin
        if (Tclr) begin
            state_q     <= ST_GET_OP;
            a_q         <= '0;
            b_q         <= '0;
            sel_q       <= '0;
            cnt_q       <= '0;
            res_data_q  <= '0;
            res_op_q    <= '0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            res_data_q  <= res_data_d;
            res_op_q    <= res_op_d;
            res_valid_q <= res_valid_d;
            err_q       <= err_d;
        end
    end

    // in_ready is decoded from state only, so a beat is taken whenever in_valid is seen in a GET state.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        res_data_d  = res_data_q;
        res_op_d    = res_op_q;
        res_valid_d = res_valid_q;
        err_d       = 1'b0;
        case (state_q)
            ST_GET_OP: begin
                if (in_valid) begin
                    if (in_data[N-1:3] != '0) begin
                        err_d = 1'b1;
                    end else begin
                        sel_d   = in_data[2:0];
                        state_d = ST_GET_A;
                    end
                end
            end
            ST_GET_A: begin
                if (in_valid) begin
                    a_d     = in_data;
                    state_d = ST_GET_B;
                end
            end
            ST_GET_B: begin
                if (in_valid) begin
                    b_d     = in_data;
                    cnt_d   = (sel_q == c_sel_mul) ? c_cnt_mul : c_cnt_alu;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_q == '0) begin
                    res_data_d  = (sel_q == c_sel_mul) ? ula_Smulti
                                                       : {{(N-1){1'b0}}, ula_S};
                    res_op_d    = sel_q;
                    res_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_GET_OP;
                end
            end
            default: state_d = ST_GET_OP;
        endcase
    end

    assign in_ready  = (state_q == ST_GET_OP) || (state_q == ST_GET_A) || (state_q == ST_GET_B);
    assign ula_en    = (state_q == ST_EXEC);
    assign ula_A     = a_q;
    assign ula_B     = b_q;
    assign ula_sel   = sel_q;
    assign res_data  = res_data_q;
    assign res_op    = res_op_q;
    assign res_valid = res_valid_q;
    assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ula_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ula_op_sequencer
// Description : Scoreboard bench for ula_op_sequencer with a behavioural ULA.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ula_op_sequencer;

    localparam int N       = 8;
    localparam int LAT_ALU = 1;
    localparam int LAT_MUL = 8;

    logic           Tclk = 1'b0;
    logic           Tclr;
    logic [N-1:0]   in_data;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   ula_A, ula_B;
    logic [2:0]     ula_sel;
    logic           ula_en;
    logic [N:0]     ula_S;
    logic [2*N-1:0] ula_Smulti;
    logic [2*N-1:0] res_data;
    logic [2:0]     res_op;
    logic           res_valid;
    logic           res_ready;
    logic           err;

    int checks = 0;
    int passes = 0;
    int beats  = 0;
    int en_cnt = 0;
    logic [18:0] sb_q[$];   // {op, data}

    ula_op_sequencer #(.N(N), .LAT_ALU(LAT_ALU), .LAT_MUL(LAT_MUL)) dut (
        .Tclk(Tclk), .Tclr(Tclr), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .ula_A(ula_A), .ula_B(ula_B), .ula_sel(ula_sel),
        .ula_en(ula_en), .ula_S(ula_S), .ula_Smulti(ula_Smulti),
        .res_data(res_data), .res_op(res_op), .res_valid(res_valid),
        .res_ready(res_ready), .err(err)
    );

    always #5 Tclk = ~Tclk;

    // ULA stand-in: the product only becomes valid in the LAT_MUL-th enabled cycle.
    always @(posedge Tclk) en_cnt <= ula_en ? en_cnt + 1 : 0;
    always_comb begin
        ula_S      = (ula_sel == 3'b000) ? ({1'b0, ula_A} + {1'b0, ula_B}) : {1'b0, ula_A ^ ula_B};
        ula_Smulti = (en_cnt >= LAT_MUL - 1) ? (ula_A * ula_B) : 16'hDEAD;
    end

    always @(negedge Tclk) begin
        if (in_valid && in_ready) beats = beats + 1;
        if (res_valid && res_ready) begin
            logic [18:0] e;
            checks = checks + 1;
            if (sb_q.size() == 0) begin
                $display("FAIL sb_unexpected: got op=%0d data=%0d, required no result", res_op, res_data);
            end else begin
                e = sb_q.pop_front();
                if ({res_op, res_data} !== e)
                    $display("FAIL sb_result: got op=%0d data=%0d, required op=%0d data=%0d",
                             res_op, res_data, e[18:16], e[15:0]);
                else passes = passes + 1;
            end
        end
    end

    task automatic tick();
        @(posedge Tclk); #1;
    endtask

    // Leaves in_valid high so callers can stream beats back to back.
    task automatic send_beat(input logic [7:0] d);
        logic rdy;
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 200; t++) begin
            rdy = in_ready;
            tick();
            if (rdy) return;
        end
        checks = checks + 1;
        $display("FAIL beat_timeout: in_ready=%b, required 1 within 200 cycles", in_ready);
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                            input bit push, input logic [15:0] exp);
        send_beat(op);
        send_beat(a);
        if (push) sb_q.push_back({op[2:0], exp});
        send_beat(b);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((sb_q.size() != 0 || res_valid) && t < 300) begin
            tick();
            t++;
        end
        checks = checks + 1;
        if (sb_q.size() != 0 || res_valid)
            $display("FAIL drain: pending=%0d res_valid=%b, required 0 and 0", sb_q.size(), res_valid);
        else passes = passes + 1;
    endtask

    task automatic test_reset();
        Tclr = 1'b1; in_valid = 1'b0; in_data = '0; res_ready = 1'b1;
        tick(); tick();
        Tclr = 1'b0;
        checks = checks + 1;
        if ({in_ready, ula_en, ula_A, ula_B, ula_sel, res_data, res_op, res_valid, err} !==
            {1'b1, 1'b0, 8'd0, 8'd0, 3'd0, 16'd0, 3'd0, 1'b0, 1'b0})
            $display("FAIL reset_state: in_ready=%b en=%b A=%0d B=%0d sel=%0d res=%0d op=%0d v=%b err=%b, required 1,0 and all else 0",
                     in_ready, ula_en, ula_A, ula_B, ula_sel, res_data, res_op, res_valid, err);
        else passes = passes + 1;
    endtask

    task automatic run_exec(input string nm, input int lat, input logic [2:0] sel,
                            input logic [7:0] a, input logic [7:0] b);
        int  en_cycles = 0;
        bit  stable = 1'b1;
        while (ula_en && en_cycles < 50) begin
            if (ula_A !== a || ula_B !== b || ula_sel !== sel || in_ready !== 1'b0) stable = 1'b0;
            en_cycles++;
            tick();
        end
        checks = checks + 1;
        if (en_cycles != lat)
            $display("FAIL %s_en_cycles: got %0d, required %0d", nm, en_cycles, lat);
        else passes = passes + 1;
        checks = checks + 1;
        if (!stable) $display("FAIL %s_operands: got unstable A/B/sel/in_ready, required %0d/%0d/%0d/0", nm, a, b, sel);
        else passes = passes + 1;
        checks = checks + 1;
        if (res_valid !== 1'b1) $display("FAIL %s_latency: got res_valid=%b, required 1", nm, res_valid);
        else passes = passes + 1;
    endtask

    task automatic test_mul();
        res_ready = 1'b1;
        send_cmd(8'h07, 8'd55, 8'd10, 1'b1, 16'd550);
        run_exec("mul", LAT_MUL, 3'b111, 8'd55, 8'd10);
        wait_drain();
    endtask

    task automatic test_alu();
        send_cmd(8'h00, 8'd100, 8'd254, 1'b1, 16'd354);
        run_exec("alu", LAT_ALU, 3'b000, 8'd100, 8'd254);
        wait_drain();
    endtask

    task automatic test_illegal();
        send_beat(8'h0F);
        in_valid = 1'b0;
        checks = checks + 1;
        if ({err, in_ready, ula_en} !== 3'b110)
            $display("FAIL illegal_err: got err=%b in_ready=%b en=%b, required 1 1 0", err, in_ready, ula_en);
        else passes = passes + 1;
        tick();
        checks = checks + 1;
        if ({err, in_ready, ula_en} !== 3'b010)
            $display("FAIL illegal_pulse: got err=%b in_ready=%b en=%b, required 0 1 0", err, in_ready, ula_en);
        else passes = passes + 1;
        send_cmd(8'h00, 8'd10, 8'd89, 1'b1, 16'd99);
        wait_drain();
    endtask

    task automatic test_backpressure();
        logic [15:0] d0;
        int t = 0;
        res_ready = 1'b0;
        send_cmd(8'h00, 8'd3, 8'd4, 1'b1, 16'd7);
        while (!res_valid && t < 50) begin tick(); t++; end
        d0 = res_data;
        checks = checks + 1;
        if (d0 !== 16'd7) $display("FAIL bp_data: got %0d, required 7", d0);
        else passes = passes + 1;
        in_valid = 1'b1; in_data = 8'hAA;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks = checks + 1;
            if ({res_valid, in_ready, res_data, res_op} !== {1'b1, 1'b0, 16'd7, 3'd0})
                $display("FAIL bp_hold%0d: got v=%b rdy=%b data=%0d op=%0d, required 1 0 7 0",
                         i, res_valid, in_ready, res_data, res_op);
            else passes = passes + 1;
        end
        in_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        checks = checks + 1;
        if ({res_valid, in_ready} !== 2'b01)
            $display("FAIL bp_release: got v=%b rdy=%b, required 0 1", res_valid, in_ready);
        else passes = passes + 1;
        wait_drain();
    endtask

    task automatic test_reset_abort();
        send_cmd(8'h07, 8'd10, 8'd90, 1'b0, 16'd0);
        tick(); tick();
        Tclr = 1'b1;
        tick();
        Tclr = 1'b0;
        checks = checks + 1;
        if ({in_ready, ula_en, ula_A, ula_B, ula_sel, res_data, res_op, res_valid, err} !==
            {1'b1, 1'b0, 8'd0, 8'd0, 3'd0, 16'd0, 3'd0, 1'b0, 1'b0})
            $display("FAIL abort_state: in_ready=%b en=%b A=%0d B=%0d sel=%0d res=%0d v=%b, required 1,0 and all else 0",
                     in_ready, ula_en, ula_A, ula_B, ula_sel, res_data, res_valid);
        else passes = passes + 1;
        send_cmd(8'h07, 8'd10, 8'd90, 1'b1, 16'd900);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int b0 = beats;
        logic [7:0] a, b;
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            if (i % 2 == 0) begin
                send_beat(8'h07); send_beat(a);
                sb_q.push_back({3'b111, 16'(a * b)});
            end else begin
                send_beat(8'h00); send_beat(a);
                sb_q.push_back({3'b000, 16'({1'b0, a} + {1'b0, b})});
            end
            send_beat(b);
        end
        in_valid = 1'b0;
        wait_drain();
        checks = checks + 1;
        if (beats - b0 != 12) $display("FAIL b2b_beats: got %0d, required 12", beats - b0);
        else passes = passes + 1;
    endtask

    initial begin
        test_reset();
        test_mul();
        test_alu();
        test_illegal();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
